// File: rtl/scan_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_seq_pkg
// Purpose  : Shared types and helpers for the scan sequencer: FSM state
//            encoding, digit count/select width, and the wrapping priority
//            search used to pick the next enabled digit.
// Revision : 1.0 - initial release
// ============================================================================
package scan_seq_pkg;

  localparam int N_DIGITS = 4;
  localparam int SEL_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // First set mask bit searching upward from cur+1, wrapping 3->0.
  // Returns cur itself when it is the only enabled digit (or if no bit is
  // set, which callers exclude beforehand).
  function automatic logic [SEL_W-1:0] next_digit(
    input logic [N_DIGITS-1:0] mask,
    input logic [SEL_W-1:0]    cur
  );
    logic [SEL_W-1:0] idx;
    next_digit = cur;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = N_DIGITS; k >= 1; k--) begin
      idx = cur + SEL_W'(k);
      if (mask[idx]) next_digit = idx;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_cnt.sv
`default_nettype none
// ============================================================================
// Module   : scan_tick_cnt
// Purpose  : Terminal-count tick counter. Counts enabled cycles from 0 up to
//            TERM-1, pulses o_tc combinationally in the last counted cycle and
//            wraps to 0. i_clr has priority and suppresses o_tc.
// Ports    : clk, rst_n (async active-low), i_clr, i_en -> o_tc
// Revision : 1.0 - initial release
// ============================================================================
module scan_tick_cnt #(
  parameter int unsigned TERM = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned     CNT_W  = $clog2(TERM + 1);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TERM - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc = i_en && !i_clr && (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/scan_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_seq_ctrl
// Purpose  : Scan sequencer feeding a 2-to-4 one-hot enable decoder. Dwells
//            PRESCALE clocks on each digit enabled in i_digit_mask, skips
//            masked digits, wraps 3->0 and pulses o_frame_done on each wrap.
// Config   : SCAN_BLANK_EN - when defined, inserts BLANK_CYC en-low clocks
//            between digits (sel held on the old digit during the gap).
// Ports    : clk           system clock
//            rst_n         asynchronous active-low reset
//            i_run         1 = scan, 0 = stop (restart from lowest digit)
//            i_digit_mask  bit i = digit i takes part in the scan
//            o_sel         registered digit index to decoder a[1:0]
//            o_en          registered decoder enable
//            o_frame_done  1-clock pulse coincident with a wrapping sel update
//            o_busy        high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module scan_seq_ctrl
  import scan_seq_pkg::*;
#(
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_run,
  input  logic [N_DIGITS-1:0] i_digit_mask,
  output logic [SEL_W-1:0]    o_sel,
  output logic                o_en,
  output logic                o_frame_done,
  output logic                o_busy
);

  if (PRESCALE < 1 || BLANK_CYC < 1) begin : g_param_chk
    $error("scan_seq_ctrl: PRESCALE and BLANK_CYC must be >= 1");
  end

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic             r_en, w_en_nxt;
  logic             r_fd, w_fd_nxt;
  logic [SEL_W-1:0] w_next, w_first;
  logic             w_dwell_tc;
  logic             w_mask_any;

  assign w_mask_any = |i_digit_mask;
  assign w_next     = next_digit(i_digit_mask, r_sel);
  // Searching upward from the top digit lands on the lowest enabled one.
  assign w_first    = next_digit(i_digit_mask, SEL_W'(N_DIGITS - 1));

  // Clearing on !i_run also masks the terminal count, so stop beats wrap.
  scan_tick_cnt #(.TERM(PRESCALE)) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (!i_run || (r_state != ST_DWELL)),
    .i_en  (r_state == ST_DWELL),
    .o_tc  (w_dwell_tc)
  );

`ifdef SCAN_BLANK_EN
  logic             w_blank_tc;
  logic [SEL_W-1:0] r_pend_sel, w_pend_sel_nxt;
  logic             r_pend_wrap, w_pend_wrap_nxt;

  scan_tick_cnt #(.TERM(BLANK_CYC)) u_blank_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (!i_run || (r_state != ST_BLANK)),
    .i_en  (r_state == ST_BLANK),
    .o_tc  (w_blank_tc)
  );

  // Next digit and wrap flag are captured at dwell end (the only point the
  // mask is sampled) and applied when the blanking gap expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_sel  <= '0;
      r_pend_wrap <= 1'b0;
    end else begin
      r_pend_sel  <= w_pend_sel_nxt;
      r_pend_wrap <= w_pend_wrap_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_en    <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_en    <= w_en_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_en_nxt    = r_en;
    w_fd_nxt    = 1'b0;
`ifdef SCAN_BLANK_EN
    w_pend_sel_nxt  = r_pend_sel;
    w_pend_wrap_nxt = r_pend_wrap;
`endif
    case (r_state)
      ST_IDLE: begin
        w_en_nxt = 1'b0;
        if (i_run && w_mask_any) begin
          w_state_nxt = ST_DWELL;
          w_sel_nxt   = w_first;
          w_en_nxt    = 1'b1;
        end
      end
      ST_DWELL: begin
        if (!i_run) begin
          w_state_nxt = ST_IDLE;
          w_en_nxt    = 1'b0;
        end else if (w_dwell_tc) begin
          if (!w_mask_any) begin
            w_state_nxt = ST_IDLE;
            w_en_nxt    = 1'b0;
          end else begin
`ifdef SCAN_BLANK_EN
            w_state_nxt     = ST_BLANK;
            w_en_nxt        = 1'b0;
            w_pend_sel_nxt  = w_next;
            w_pend_wrap_nxt = (w_next <= r_sel);
`else
            w_sel_nxt = w_next;
            w_fd_nxt  = (w_next <= r_sel);
`endif
          end
        end
      end
`ifdef SCAN_BLANK_EN
      ST_BLANK: begin
        if (!i_run) begin
          w_state_nxt = ST_IDLE;
          w_en_nxt    = 1'b0;
        end else if (w_blank_tc) begin
          w_state_nxt = ST_DWELL;
          w_sel_nxt   = r_pend_sel;
          w_en_nxt    = 1'b1;
          w_fd_nxt    = r_pend_wrap;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

  assign o_sel        = r_sel;
  assign o_en         = r_en;
  assign o_frame_done = r_fd;
  assign o_busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_scan_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_seq_ctrl
// Purpose  : Self-checking bench for scan_seq_ctrl. A reference model tracks
//            the scan as "active digit + position within the digit period"
//            and is compared every cycle against the DUT outputs.
// Config   : honours SCAN_BLANK_EN (blank gap of BLANK_CYC clocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_seq_ctrl;

  localparam int P  = 3;
  localparam int BC = 2;
`ifdef SCAN_BLANK_EN
  localparam int B = BC;
`else
  localparam int B = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_run;
  logic [3:0] i_digit_mask;
  logic [1:0] o_sel;
  logic       o_en, o_frame_done, o_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_seq_ctrl #(.PRESCALE(P), .BLANK_CYC(BC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_run        (i_run),
    .i_digit_mask (i_digit_mask),
    .o_sel        (o_sel),
    .o_en         (o_en),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  // ---------------- reference model ----------------
  logic       m_active, m_en, m_fd;
  logic [1:0] m_sel, m_pend;
  int         m_t;   // position inside the digit period: 0..P-1 lit, P..P+B-1 dark

  function automatic logic [1:0] m_next(input logic [3:0] mask, input int cur);
    for (int k = 1; k <= 4; k++) begin
      int d;
      d = (cur + k) % 4;
      if (mask[d]) return 2'(d);
    end
    return 2'(cur);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_en <= 1'b0; m_fd <= 1'b0;
      m_sel <= 2'd0; m_pend <= 2'd0; m_t <= 0;
    end else begin
      m_fd <= 1'b0;
      if (!m_active) begin
        m_en <= 1'b0;
        if (i_run && i_digit_mask != 4'd0) begin
          m_active <= 1'b1; m_sel <= m_next(i_digit_mask, 3); m_t <= 0; m_en <= 1'b1;
        end
      end else if (!i_run) begin
        m_active <= 1'b0; m_en <= 1'b0;
      end else if (m_t == P - 1) begin
        if (i_digit_mask == 4'd0) begin
          m_active <= 1'b0; m_en <= 1'b0;
        end else if (B == 0) begin
          m_fd  <= (m_next(i_digit_mask, int'(m_sel)) <= m_sel);
          m_sel <= m_next(i_digit_mask, int'(m_sel));
          m_t   <= 0;
        end else begin
          m_pend <= m_next(i_digit_mask, int'(m_sel));
          m_t    <= P; m_en <= 1'b0;
        end
      end else if (m_t == P + B - 1) begin
        m_fd <= (m_pend <= m_sel); m_sel <= m_pend; m_t <= 0; m_en <= 1'b1;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  logic [4:0] w_got, w_exp;
  assign w_got = {o_sel, o_en, o_frame_done, o_busy};
  assign w_exp = {m_sel, m_en, m_fd, m_active};

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; i_run = 1'b0; i_digit_mask = 4'd0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (w_got !== 5'b0)
        begin errors++; $display("FAIL reset_hold got %b exp %b", w_got, 5'b0); end
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (w_got !== w_exp)
        begin errors++; $display("FAIL reset_idle got %b exp %b", w_got, w_exp); end
    end
  endtask

  task automatic go_idle();
    i_run = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_scan();
    go_idle();
    i_digit_mask = 4'b1111; i_run = 1'b1;
    for (int c = 0; c < 6 * (P + B); c++) begin
      @(negedge clk);
      checks++;
      if (w_got !== w_exp)
        begin errors++; $display("FAIL full_scan cyc %0d got %b exp %b", c, w_got, w_exp); end
    end
  endtask

  task automatic test_sparse();
    go_idle();
    i_digit_mask = 4'b1010; i_run = 1'b1;
    for (int c = 0; c < 5 * (P + B); c++) begin
      @(negedge clk);
      checks++;
      if (w_got !== w_exp)
        begin errors++; $display("FAIL sparse cyc %0d got %b exp %b", c, w_got, w_exp); end
      checks++;
      if (o_en && !o_sel[0])
        begin errors++; $display("FAIL sparse_skip cyc %0d got sel=%0d exp sel in {1,3}", c, o_sel); end
    end
  endtask

  task automatic test_single_then_off();
    go_idle();
    i_digit_mask = 4'b0100; i_run = 1'b1;
    for (int c = 0; c < 4 * (P + B); c++) begin
      @(negedge clk);
      checks++;
      if (w_got !== w_exp)
        begin errors++; $display("FAIL single cyc %0d got %b exp %b", c, w_got, w_exp); end
    end
    i_digit_mask = 4'b0000;
    for (int c = 0; c < P + B + 2; c++) begin
      @(negedge clk);
      checks++;
      if (w_got !== w_exp)
        begin errors++; $display("FAIL mask_off cyc %0d got %b exp %b", c, w_got, w_exp); end
    end
    checks++;
    if (o_en !== 1'b0 || o_busy !== 1'b0)
      begin errors++; $display("FAIL mask_off_idle got en=%b busy=%b exp en=0 busy=0", o_en, o_busy); end
  endtask

  task automatic test_stop_at_tc();
    int c;
    go_idle();
    i_digit_mask = 4'b0110; i_run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    c = 0;
    while (!(m_active && m_t == P - 1) && c < 20) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (!(m_active && m_t == P - 1)) begin
      errors++; $display("FAIL stop_tc_wait got timeout exp terminal-count cycle");
    end
    i_run = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_en, o_busy, o_frame_done} !== 3'b000)
      begin errors++; $display("FAIL stop_tc got en/busy/fd=%b exp 000", {o_en, o_busy, o_frame_done}); end
    i_run = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_en, o_sel} !== 3'b101)
      begin errors++; $display("FAIL restart got en/sel=%b exp 101", {o_en, o_sel}); end
    checks++;
    if (w_got !== w_exp)
      begin errors++; $display("FAIL restart_model got %b exp %b", w_got, w_exp); end
  endtask

  task automatic test_async_reset();
    go_idle();
    i_digit_mask = 4'b1111; i_run = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (w_got !== 5'b0)
      begin errors++; $display("FAIL async_rst got %b exp %b", w_got, 5'b0); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (w_got !== 5'b0)
        begin errors++; $display("FAIL async_rst_hold got %b exp %b", w_got, 5'b0); end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2 * (P + B); c++) begin
      @(negedge clk);
      checks++;
      if (w_got !== w_exp)
        begin errors++; $display("FAIL post_rst cyc %0d got %b exp %b", c, w_got, w_exp); end
    end
  endtask

  task automatic test_random();
    go_idle();
    i_run = 1'b1; i_digit_mask = 4'($urandom_range(1, 15));
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 19) == 0) i_run = ~i_run;
      if ($urandom_range(0, 7) == 0)  i_digit_mask = 4'($urandom_range(0, 15));
      @(negedge clk);
      checks++;
      if (w_got !== w_exp)
        begin errors++; $display("FAIL random cyc %0d got %b exp %b", c, w_got, w_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse();
    test_single_then_off();
    test_stop_at_tc();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
